// File: rtl/guitar_pkg.sv
// rtl/guitar_pkg.sv - shared defaults and state encoding for the scoring stage
package guitar_pkg;

    localparam int SCORE_W_DEF          = 32;
    localparam int POINTS_DEF           = 50;
    localparam int STREAK_PER_LEVEL_DEF = 10;
    localparam int MAX_MULT_DEF         = 4;
    localparam int LOCKOUT_DEF          = 8;

    typedef enum logic {
        READY    = 1'b0,
        COOLDOWN = 1'b1
    } state_t;

endpackage

// File: rtl/combo_counter.sv
// rtl/combo_counter.sv - streak, best streak and combo multiplier tracking
import guitar_pkg::*;

module combo_counter #(
    parameter int STREAK_PER_LEVEL = STREAK_PER_LEVEL_DEF,
    parameter int MAX_MULT         = MAX_MULT_DEF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        hit_evt,
    input  logic        miss_evt,
    output logic [15:0] streak,
    output logic [15:0] best_streak,
    output logic [2:0]  multiplier
);

    localparam int LVL_W = $clog2(STREAK_PER_LEVEL + 1);

    logic [LVL_W-1:0] level_cnt;
    logic [15:0]      streak_inc;

    // Streak saturates rather than wrapping so a very long run never looks like a miss
    assign streak_inc = (streak == 16'hFFFF) ? streak : streak + 16'd1;

    // Combo state: clear beats hit beats miss; the top never raises hit and miss together
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            streak      <= '0;
            best_streak <= '0;
            level_cnt   <= '0;
            multiplier  <= 3'd1;
        end else if (clear) begin
            streak     <= '0;
            level_cnt  <= '0;
            multiplier <= 3'd1;
        end else if (hit_evt) begin
            streak <= streak_inc;
            if (streak_inc > best_streak) begin
                best_streak <= streak_inc;
            end
            if (level_cnt == LVL_W'(STREAK_PER_LEVEL - 1)) begin
                level_cnt <= '0;
                if (multiplier < 3'(MAX_MULT)) begin
                    multiplier <= multiplier + 3'd1;
                end
            end else begin
                level_cnt <= level_cnt + LVL_W'(1);
            end
        end else if (miss_evt) begin
            streak     <= '0;
            level_cnt  <= '0;
            multiplier <= 3'd1;
        end
    end

endmodule

// File: rtl/score_tracker.sv
// rtl/score_tracker.sv - strum lockout, hit/miss arbitration and saturating score
import guitar_pkg::*;

module score_tracker #(
    parameter int SCORE_W          = SCORE_W_DEF,
    parameter int POINTS           = POINTS_DEF,
    parameter int STREAK_PER_LEVEL = STREAK_PER_LEVEL_DEF,
    parameter int MAX_MULT         = MAX_MULT_DEF,
    parameter int LOCKOUT          = LOCKOUT_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               update,
    input  logic               inc,
    input  logic               note_expire,
    output logic [SCORE_W-1:0] score,
    output logic [15:0]        streak,
    output logic [15:0]        best_streak,
    output logic [2:0]         multiplier,
    output logic               hit,
    output logic               miss,
    output logic               lockout
);

    localparam int CNT_W = (LOCKOUT > 2) ? $clog2(LOCKOUT) : 1;
    localparam logic [SCORE_W:0] PTS = (SCORE_W + 1)'(POINTS);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             hit_evt;
    logic             miss_evt;
    logic [SCORE_W:0] product;
    logic [SCORE_W:0] sum;

    // A hit swallows a coincident expiry; strum-miss and expiry merge into one miss
    assign accept   = update && (state == READY);
    assign hit_evt  = accept && inc;
    assign miss_evt = !hit_evt && (accept || note_expire);

    // One extra bit catches the carry so the score can clamp instead of wrapping
    assign product = PTS * (SCORE_W + 1)'(multiplier);
    assign sum     = {1'b0, score} + product;

    // Lockout FSM plus registered score and event pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= READY;
            cnt     <= '0;
            lockout <= 1'b0;
            hit     <= 1'b0;
            miss    <= 1'b0;
            score   <= '0;
        end else if (clear) begin
            state   <= READY;
            cnt     <= '0;
            lockout <= 1'b0;
            hit     <= 1'b0;
            miss    <= 1'b0;
            score   <= '0;
        end else begin
            hit  <= hit_evt;
            miss <= miss_evt;
            if (hit_evt) begin
                score <= sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
            end
            case (state)
                READY: begin
                    if (update && (LOCKOUT > 1)) begin
                        state   <= COOLDOWN;
                        cnt     <= CNT_W'(LOCKOUT - 1);
                        lockout <= 1'b1;
                    end
                end
                COOLDOWN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state   <= READY;
                        lockout <= 1'b0;
                    end
                end
                default: begin
                    state   <= READY;
                    lockout <= 1'b0;
                end
            endcase
        end
    end

    combo_counter #(
        .STREAK_PER_LEVEL (STREAK_PER_LEVEL),
        .MAX_MULT         (MAX_MULT)
    ) u_combo (
        .clock       (clock),
        .reset_n     (reset_n),
        .clear       (clear),
        .hit_evt     (hit_evt),
        .miss_evt    (miss_evt),
        .streak      (streak),
        .best_streak (best_streak),
        .multiplier  (multiplier)
    );

endmodule

// File: tb/tb_score_tracker.sv
// tb/tb_score_tracker.sv - self-checking bench for score_tracker
module tb_score_tracker;

    localparam int LOCK    = 8;
    localparam int SMALL_W = 12;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic        update = 1'b0;
    logic        inc = 1'b0;
    logic        note_expire = 1'b0;

    logic [31:0] score;
    logic [15:0] streak, best_streak;
    logic [2:0]  multiplier;
    logic        hit, miss, lockout;

    logic [SMALL_W-1:0] s_score;
    logic [15:0] s_streak, s_best;
    logic [2:0]  s_mult;
    logic        s_hit, s_miss, s_lockout;

    int checks = 0;
    int failures = 0;
    bit run_cmp = 1'b0;

    // Behavioural model state
    longint m_score_big = 0;
    longint m_score_small = 0;
    int     m_streak = 0;
    int     m_best = 0;
    int     m_run = 0;
    bit     m_hit = 0;
    bit     m_miss = 0;
    longint edge_no = 0;
    longint last_acc = -1000;

    score_tracker dut (
        .clock(clock), .reset_n(reset_n), .clear(clear), .update(update),
        .inc(inc), .note_expire(note_expire), .score(score), .streak(streak),
        .best_streak(best_streak), .multiplier(multiplier), .hit(hit),
        .miss(miss), .lockout(lockout)
    );

    score_tracker #(.SCORE_W(SMALL_W)) dut_s (
        .clock(clock), .reset_n(reset_n), .clear(clear), .update(update),
        .inc(inc), .note_expire(note_expire), .score(s_score), .streak(s_streak),
        .best_streak(s_best), .multiplier(s_mult), .hit(s_hit),
        .miss(s_miss), .lockout(s_lockout)
    );

    always #5 clock = ~clock;

    function automatic int exp_mult(input int run);
        int m;
        m = 1 + run / 10;
        return (m > 4) ? 4 : m;
    endfunction

    function automatic longint sat_add(input longint a, input longint b, input int w);
        longint lim;
        lim = (longint'(1) << w) - 1;
        return (a + b > lim) ? lim : a + b;
    endfunction

    function automatic bit exp_lock();
        return (edge_no + 1 - last_acc) < LOCK;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: rules applied directly to each sampled edge
    always @(posedge clock or negedge reset_n) begin
        bit acc, h, ms;
        int mult_before;
        if (!reset_n) begin
            m_score_big = 0; m_score_small = 0; m_streak = 0; m_best = 0;
            m_run = 0; m_hit = 0; m_miss = 0; edge_no = 0; last_acc = -1000;
        end else begin
            edge_no++;
            if (clear) begin
                m_score_big = 0; m_score_small = 0; m_streak = 0; m_run = 0;
                m_hit = 0; m_miss = 0; last_acc = -1000;
            end else begin
                acc = update && (edge_no - last_acc >= LOCK);
                if (acc) last_acc = edge_no;
                h  = acc && inc;
                ms = !h && (acc || note_expire);
                if (h) begin
                    mult_before   = exp_mult(m_run);
                    m_score_big   = sat_add(m_score_big, 50 * mult_before, 32);
                    m_score_small = sat_add(m_score_small, 50 * mult_before, SMALL_W);
                    m_run++;
                    m_streak = (m_streak == 65535) ? 65535 : m_streak + 1;
                    if (m_streak > m_best) m_best = m_streak;
                end else if (ms) begin
                    m_run = 0;
                    m_streak = 0;
                end
                m_hit = h;
                m_miss = ms;
            end
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clock) begin
        if (run_cmp) begin
            chk("cyc_score", score, m_score_big);
            chk("cyc_streak", streak, m_streak);
            chk("cyc_best", best_streak, m_best);
            chk("cyc_mult", multiplier, exp_mult(m_run));
            chk("cyc_hit", hit, m_hit);
            chk("cyc_miss", miss, m_miss);
            chk("cyc_lockout", lockout, exp_lock());
            chk("cyc_small_score", s_score, m_score_small);
            chk("cyc_small_lockout", s_lockout, exp_lock());
        end
    end

    task automatic pulse(input logic u, input logic i, input logic e, input logic c);
        update = u; inc = i; note_expire = e; clear = c;
        @(negedge clock);
        update = 0; inc = 0; note_expire = 0; clear = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic hit_spaced(input int n);
        for (int k = 0; k < n; k++) begin
            pulse(1, 1, 0, 0);
            idle(LOCK - 1);
        end
    endtask

    initial begin
        idle(3);
        run_cmp = 1'b1;
        chk("rst_score", score, 0);
        chk("rst_mult", multiplier, 1);
        chk("rst_lockout", lockout, 0);
        reset_n = 1'b1;

        // first hit right after reset release
        pulse(1, 1, 0, 0);
        chk("first_score", score, 50);
        chk("first_streak", streak, 1);
        chk("first_hit", hit, 1);
        chk("first_lockout", lockout, 1);
        idle(1);
        chk("first_hit_drop", hit, 0);

        // lockout window: strums at +3 and +7 ignored, +8 accepted
        idle(1);
        pulse(1, 1, 0, 0);
        chk("lock3_score", score, 50);
        chk("lock3_lockout", lockout, 1);
        idle(3);
        pulse(1, 1, 0, 0);
        chk("lock7_score", score, 50);
        chk("lock7_hit", hit, 0);
        pulse(1, 1, 0, 0);
        chk("lock8_score", score, 100);
        chk("lock8_streak", streak, 2);

        // multiplier climb
        pulse(0, 0, 0, 1);
        chk("clr_score", score, 0);
        chk("clr_best", best_streak, 2);
        hit_spaced(10);
        chk("climb10_mult", multiplier, 2);
        chk("climb10_score", score, 500);
        hit_spaced(1);
        chk("climb11_score", score, 600);
        hit_spaced(4);
        chk("streak15", streak, 15);

        // miss by expiry, then by wrong fret
        pulse(0, 0, 1, 0);
        chk("exp_streak", streak, 0);
        chk("exp_mult", multiplier, 1);
        chk("exp_score", score, 1000);
        chk("exp_best", best_streak, 15);
        chk("exp_miss", miss, 1);
        idle(1);
        hit_spaced(3);
        pulse(1, 0, 0, 0);
        chk("wrong_streak", streak, 0);
        chk("wrong_score", score, 1150);
        chk("wrong_miss", miss, 1);
        idle(LOCK - 1);

        // simultaneous events
        pulse(1, 1, 1, 0);
        chk("sim_hit", hit, 1);
        chk("sim_hit_nomiss", miss, 0);
        chk("sim_hit_streak", streak, 1);
        idle(LOCK - 1);
        pulse(1, 0, 1, 0);
        chk("sim_miss", miss, 1);
        idle(1);
        chk("sim_miss_single", miss, 0);
        idle(LOCK - 2);

        // expiry honoured during cooldown
        pulse(1, 1, 0, 0);
        idle(2);
        pulse(0, 0, 1, 0);
        chk("cool_exp_streak", streak, 0);
        chk("cool_exp_lock", lockout, 1);
        idle(LOCK);

        // clear during cooldown overrides everything
        pulse(1, 1, 0, 0);
        idle(2);
        pulse(1, 1, 1, 1);
        chk("cclr_score", score, 0);
        chk("cclr_lockout", lockout, 0);
        chk("cclr_hit", hit, 0);
        chk("cclr_miss", miss, 0);
        chk("cclr_best", best_streak, 15);
        pulse(1, 1, 0, 0);
        chk("post_clr_score", score, 50);
        idle(LOCK - 1);

        // saturation on the narrow instance
        pulse(0, 0, 0, 1);
        hit_spaced(36);
        chk("sat_small", s_score, 4095);
        chk("sat_big", score, 4200);
        chk("sat_mult", multiplier, 4);
        hit_spaced(1);
        chk("sat_small_hold", s_score, 4095);
        chk("sat_big_next", score, 4400);
        chk("sat_best", best_streak, 37);

        // asynchronous reset mid-cooldown
        pulse(1, 1, 0, 0);
        idle(1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_score", score, 0);
        chk("arst_lockout", lockout, 0);
        chk("arst_best", best_streak, 0);
        @(negedge clock);
        reset_n = 1'b1;
        pulse(1, 1, 0, 0);
        chk("arst_first_score", score, 50);
        chk("arst_first_streak", streak, 1);
        idle(2);

        run_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_tracker.md
# score_tracker

Sequential scoring stage directly downstream of the fret/strum comparator. It consumes the per-strum `update` pulse and the `inc` (all frets correct) flag, plus a note-expiry strobe from the note scheduler. It maintains score, streak, best streak and combo multiplier. Its `score` output is the data word written back to r28 whenever the writeback stage flags a score write.

## Interface
Parameters:
- `SCORE_W`, 32: score width.
- `POINTS`, 50: base points per hit.
- `STREAK_PER_LEVEL`, 10: consecutive hits per multiplier step.
- `MAX_MULT`, 4: multiplier ceiling.
- `LOCKOUT`, 8: cycles after an accepted strum during which further strums are ignored.

Ports:
- `clock` in 1: single clock. Everything is rising-edge.
- `reset_n` in 1: asynchronous active-low reset.
- `clear` in 1: synchronous start-of-song clear.
- `update` in 1: one-cycle strum-edge pulse.
- `inc` in 1: fret pattern matched the intersections. Sampled only with `update`.
- `note_expire` in 1: one-cycle pulse when a note leaves the hit window unstrummed.
- `score` out SCORE_W: running score.
- `streak` out 16: current consecutive hits.
- `best_streak` out 16: maximum streak since reset.
- `multiplier` out 3: current combo multiplier, range 1..MAX_MULT.
- `hit` out 1: one-cycle pulse on a scored hit.
- `miss` out 1: one-cycle pulse on a miss.
- `lockout` out 1: high while strums are being ignored.

## Operation
- **States:** READY and COOLDOWN.
- **Strum accepted:** `update` in READY is accepted. The block moves to COOLDOWN with the down-counter loaded to LOCKOUT-1. It returns to READY when the counter reaches 0.
- **Strum ignored:** `update` in COOLDOWN is ignored entirely. There is no hit, no miss and no counter reload.
- **Hit (accepted `update` with `inc`=1):**
  - `score` += POINTS × `multiplier`, using the multiplier value before this hit. The sum saturates at 2^SCORE_W−1.
  - `streak` += 1, saturating at 0xFFFF.
  - `level_cnt` += 1. When it reaches STREAK_PER_LEVEL it wraps to 0 and `multiplier` increments, saturating at MAX_MULT.
  - `best_streak` = max(`best_streak`, new `streak`).
- **Miss:** an accepted `update` with `inc`=0, or `note_expire`=1.
  - `streak` and `level_cnt` go to 0.
  - `multiplier` goes to 1.
  - `score` is unchanged.
- **Simultaneous events:**
  - A hit and `note_expire` in the same cycle: the hit wins and the expiry is dropped.
  - A strum-miss and `note_expire` in the same cycle: a single `miss` pulse.
  - `note_expire` is honoured in both READY and COOLDOWN.
- **`clear`:**
  - Sets `score`, `streak` and `level_cnt` to 0, `multiplier` to 1, and the state to READY with the counter at 0.
  - Preserves `best_streak`.
  - Overrides every other input in that cycle; no `hit` or `miss` is pulsed.
- **Multiplier arithmetic:** the product is computed at SCORE_W width. With POINTS × MAX_MULT = 200, the product cannot overflow.

## Timing
- All outputs are registered. An event sampled at edge N is visible after edge N.
- `hit`/`miss` pulse in the same cycle the updated `score`/`streak` appear.
- Lockout window: an accepted strum at edge N blocks strums sampled at edges N+1 through N+LOCKOUT−1. A strum at edge N+LOCKOUT is accepted. `lockout` is high exactly during the blocked window.
- Reset values: `score`=0, `streak`=0, `best_streak`=0, `multiplier`=1, `hit`=0, `miss`=0, `lockout`=0, state READY.
- Reset asserted mid-cooldown or mid-event returns to these values immediately and asynchronously. The first accepted strum can be sampled at the first rising edge after `reset_n` deasserts.

## Structure
- Shared package `guitar_pkg`:
  - Default values for POINTS, STREAK_PER_LEVEL, MAX_MULT and LOCKOUT.
  - SCORE_W.
  - State encoding: READY=0, COOLDOWN=1.
- Sub-module `combo_counter`: holds `streak`, `level_cnt`, `multiplier` and `best_streak`, with inputs hit_evt, miss_evt and clear.
- Top level holds the lockout FSM, event arbitration and the saturating score adder.

## Test plan
- **Reset and first hit:** reset, then `update`=1, `inc`=1 → `score`=50, `streak`=1, `multiplier`=1, `hit` pulses once.
- **Multiplier climb:** 10 hits spaced 8 cycles apart → `multiplier`=2 after the 10th hit, `score`=500. The 11th hit → `score`=600.
- **Lockout:** a hit at cycle 0, then `update`=1,`inc`=1 at cycles 3 and 7 → both ignored (`score`=50, `lockout`=1). `update` at cycle 8 → accepted, `score`=100.
- **Miss paths:** streak 15, multiplier 2, then `note_expire` → `streak`=0, `multiplier`=1, `score` unchanged, `best_streak`=15. A wrong-fret strum gives the same result.
- **Simultaneous events:**
  - `update`,`inc`=1 with `note_expire` → hit only, `miss`=0.
  - `update`,`inc`=0 with `note_expire` → exactly one `miss` pulse.
- **Clear and saturation:**
  - `clear` during COOLDOWN with `score`=1234 → `score`=0, `lockout`=0 next cycle, `best_streak` retained.
  - With `score` forced to 2^32−100, a ×4 hit → `score` saturates at 0xFFFFFFFF.
